// File: rtl/riscv_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// memory-wait FSM states.
package riscv_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_e;

    typedef enum logic [1:0] {
        RUN,
        MWAIT,
        TIMEOUT
    } pctl_state_e;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one Execute-stage source register.
// The younger result in Memory wins over the one in Writeback.
module fwd_unit
    import riscv_pkg::*;
(
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    output fwd_e             fwd
);

    always_comb begin
        // x0 is hardwired to zero, so a write to it never produces a value to forward.
        if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
            fwd = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
            fwd = FWD_WB;
        end else begin
            fwd = FWD_NONE;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller for a 5-stage pipeline: forwarding, load-use stall,
// branch flush and data-memory wait/timeout freeze with a stall counter.
module pipeline_ctrl
    import riscv_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt
);

    localparam int                WCNT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(WAIT_MAX);

    fwd_e              fwd_a;
    fwd_e              fwd_b;
    pctl_state_e       state;
    pctl_state_e       state_next;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_next;
    logic              lw_stall;
    logic              mem_wait;
    logic              any_stall;
    logic [CNT_W-1:0]  stall_cnt;

    fwd_unit u_fwd_a (
        .rs_e        (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs_e        (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_b)
    );

    assign lw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_wait = (MemReqM && !MemReadyM) || (state == TIMEOUT);

    assign ForwardAE = rst_n ? fwd_a : FWD_NONE;
    assign ForwardBE = rst_n ? fwd_b : FWD_NONE;

    always_comb begin
        // NOTE: every output gets a default first so no path through the if-chain infers a latch.
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst_n) begin
            // Held quiet while in reset.
        end else if (mem_wait) begin
            // Whole pipe frozen; a pending taken branch is serviced once memory completes.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        case (state)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    wcnt_next  = WCNT_ONE;
                    state_next = (WAIT_MAX <= 1) ? TIMEOUT : MWAIT;
                end
            end
            MWAIT: begin
                // A ready arriving on the final allowed wait cycle still completes cleanly.
                if (MemReadyM || !MemReqM) begin
                    wcnt_next  = '0;
                    state_next = RUN;
                end else begin
                    wcnt_next = wcnt + WCNT_ONE;
                    if (wcnt_next == WAIT_LIM) begin
                        state_next = TIMEOUT;
                    end
                end
            end
            TIMEOUT: state_next = TIMEOUT;
            default: begin
                state_next = RUN;
                wcnt_next  = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    assign any_stall = StallF || StallD || StallE || StallM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (any_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign MemErr   = (state == TIMEOUT);
    assign StallCnt = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_pipeline_ctrl;
    import riscv_pkg::*;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, loade, pcsrc, req, rdy;
    } in_t;

    typedef struct packed {
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [3:0]       stall;  // {F, D, E, M}
        logic [2:0]       flush;  // {D, E, W}
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [CNT_W-1:0] StallCnt;

    in_t   cur;
    exp_t  exp_q[$];
    string name_q[$];
    int    model_cnt = 0;
    int    checks    = 0;
    int    errors    = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdE       (RdE),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .LoadE     (LoadE),
        .PCSrcE    (PCSrcE),
        .MemReqM   (MemReqM),
        .MemReadyM (MemReadyM),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .StallM    (StallM),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .FlushW    (FlushW),
        .MemErr    (MemErr),
        .StallCnt  (StallCnt)
    );

    task automatic check(input string nm, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, field, act, exp);
        end
    endtask

    task automatic drive();
        rst_n     = cur.rst_n;
        Rs1D      = cur.rs1d;
        Rs2D      = cur.rs2d;
        Rs1E      = cur.rs1e;
        Rs2E      = cur.rs2e;
        RdE       = cur.rde;
        RdM       = cur.rdm;
        RdW       = cur.rdw;
        RegWriteM = cur.rwm;
        RegWriteW = cur.rww;
        LoadE     = cur.loade;
        PCSrcE    = cur.pcsrc;
        MemReqM   = cur.req;
        MemReadyM = cur.rdy;
    endtask

    task automatic idle();
        cur       = '0;
        cur.rst_n = 1'b1;
    endtask

    // Apply cur for one cycle and queue what the outputs must show in that cycle.
    task automatic step(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [3:0] st, input logic [2:0] fl, input logic err);
        exp_t e;
        @(posedge clk);
        #1;
        drive();
        if (!cur.rst_n) model_cnt = 0;
        e = '{fa, fb, st, fl, err, CNT_W'(model_cnt)};
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (cur.rst_n && (st != 4'b0) && (model_cnt < CNT_MAX)) model_cnt++;
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, "fwdA", int'(ForwardAE), int'(e.fa));
                check(nm, "fwdB", int'(ForwardBE), int'(e.fb));
                check(nm, "stall", int'({StallF, StallD, StallE, StallM}), int'(e.stall));
                check(nm, "flush", int'({FlushD, FlushE, FlushW}), int'(e.flush));
                check(nm, "err", int'(MemErr), int'(e.err));
                check(nm, "cnt", int'(StallCnt), int'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset with every hazard source active: all outputs must stay quiet.
        cur = '0;
        cur.rwm = 1; cur.rdm = 5; cur.rs1e = 5; cur.rs2e = 5;
        cur.loade = 1; cur.rde = 7; cur.rs2d = 7;
        cur.req = 1; cur.pcsrc = 1;
        drive();
        step("reset", 2'd0, 2'd0, 4'b0000, 3'b000, 0);
        idle();
        step("idle", 2'd0, 2'd0, 4'b0000, 3'b000, 0);

        // Forwarding priority and x0 handling.
        cur.rwm = 1; cur.rdm = 5; cur.rs1e = 5; cur.rww = 1; cur.rdw = 5;
        step("fwd_mem", 2'd2, 2'd0, 4'b0000, 3'b000, 0);
        cur.rdm = 0;
        step("fwd_mem_x0", 2'd1, 2'd0, 4'b0000, 3'b000, 0);
        cur.rdm = 5; cur.rs2e = 5;
        step("fwd_both_mem", 2'd2, 2'd2, 4'b0000, 3'b000, 0);
        cur.rwm = 0;
        step("fwd_both_wb", 2'd1, 2'd1, 4'b0000, 3'b000, 0);
        cur.rdw = 0;
        step("fwd_wb_x0", 2'd0, 2'd0, 4'b0000, 3'b000, 0);
        cur.rwm = 1; cur.rdm = 9; cur.rs2e = 9; cur.rdw = 6; cur.rs1e = 6;
        step("fwd_split", 2'd1, 2'd2, 4'b0000, 3'b000, 0);

        // Load-use hazard and branch precedence.
        idle();
        cur.loade = 1; cur.rde = 7; cur.rs2d = 7;
        step("lw_use", 2'd0, 2'd0, 4'b1100, 3'b010, 0);
        cur.loade = 0;
        step("lw_clear", 2'd0, 2'd0, 4'b0000, 3'b000, 0);
        cur.loade = 1; cur.rde = 0; cur.rs1d = 0; cur.rs2d = 0;
        step("lw_x0", 2'd0, 2'd0, 4'b0000, 3'b000, 0);
        cur.rde = 7; cur.rs1d = 7;
        step("lw_rs1", 2'd0, 2'd0, 4'b1100, 3'b010, 0);
        cur.rs2d = 7; cur.pcsrc = 1;
        step("lw_branch", 2'd0, 2'd0, 4'b0000, 3'b110, 0);

        // Memory wait freezes a taken branch, which is serviced afterwards.
        idle();
        cur.pcsrc = 1; cur.req = 1;
        step("branch_in_wait", 2'd0, 2'd0, 4'b1111, 3'b001, 0);
        cur.rdy = 1;
        step("branch_after_wait", 2'd0, 2'd0, 4'b0000, 3'b110, 0);

        cur = '0;
        step("rst_pulse", 2'd0, 2'd0, 4'b0000, 3'b000, 0);
        idle();

        // Three wait cycles then ready: StallCnt ends at 3.
        cur.req = 1;
        for (int i = 0; i < 3; i++) step("wait", 2'd0, 2'd0, 4'b1111, 3'b001, 0);
        cur.rdy = 1;
        step("wait_done", 2'd0, 2'd0, 4'b0000, 3'b000, 0);
        cur.req = 0; cur.rdy = 0;
        step("wait_run", 2'd0, 2'd0, 4'b0000, 3'b000, 0);

        // Request withdrawn mid-wait, then ready on the last allowed wait cycle.
        cur.req = 1;
        step("drop_wait", 2'd0, 2'd0, 4'b1111, 3'b001, 0);
        cur.req = 0;
        step("drop", 2'd0, 2'd0, 4'b0000, 3'b000, 0);
        cur.req = 1;
        for (int i = 0; i < WAIT_MAX - 1; i++) step("limit_wait", 2'd0, 2'd0, 4'b1111, 3'b001, 0);
        cur.rdy = 1;
        step("ready_at_limit", 2'd0, 2'd0, 4'b0000, 3'b000, 0);
        cur.req = 0; cur.rdy = 0;
        step("after_limit", 2'd0, 2'd0, 4'b0000, 3'b000, 0);

        // Timeout: error after the 4th wait cycle, then absorbing freeze.
        cur.req = 1;
        for (int i = 0; i < WAIT_MAX; i++) step("to_wait", 2'd0, 2'd0, 4'b1111, 3'b001, 0);
        step("timeout", 2'd0, 2'd0, 4'b1111, 3'b001, 1);
        cur.req = 0;
        for (int i = 0; i < 10; i++) step("to_hold", 2'd0, 2'd0, 4'b1111, 3'b001, 1);
        cur.rdy = 1; cur.pcsrc = 1; cur.loade = 1; cur.rde = 3; cur.rs1d = 3;
        step("to_override", 2'd0, 2'd0, 4'b1111, 3'b001, 1);

        // Reset asserted between edges must clear error and counter at once.
        cur = '0;
        cur.req = 1;
        step("async_rst", 2'd0, 2'd0, 4'b0000, 3'b000, 0);
        idle();
        step("post_rst", 2'd0, 2'd0, 4'b0000, 3'b000, 0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 16: consecutive memory wait cycles before timeout.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 SHALL have the ports below; all single-bit unless a width is given.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in Decode.
- Rs1E, Rs2E, RdE  in  5  source and destination registers of the instruction in Execute.
- RdM, RdW  in  5  destination registers of the instructions in Memory and Writeback.
- RegWriteM, RegWriteW  in  register-write enables for Memory and Writeback.
- LoadE  in  high when the instruction in Execute is a load.
- PCSrcE  in  high when a branch or jump in Execute is taken.
- MemReqM  in  high when the instruction in Memory accesses data memory.
- MemReadyM  in  data memory completes the access this cycle.
- ForwardAE, ForwardBE  out  2  ALU operand select (fwd_e).
- StallF, StallD, StallE, StallM  out  hold-enables for the pipeline registers.
- FlushD, FlushE, FlushW  out  bubble inserts for the IF/ID, ID/EX and MEM/WB registers.
- MemErr  out  sticky memory-timeout flag.
- StallCnt  out  CNT_W  saturating count of stalled cycles.

Function
REQ-004 SHALL drive ForwardAE = FWD_MEM when RegWriteM, RdM != 0 and RdM == Rs1E; otherwise FWD_WB when RegWriteW, RdW != 0 and RdW == Rs1E; otherwise FWD_NONE. Memory takes priority over Writeback.
REQ-005 SHALL compute ForwardBE with the rule of REQ-004, using Rs2E in place of Rs1E.
REQ-006 SHALL define lwStall = LoadE and RdE != 0 and (RdE == Rs1D or RdE == Rs2D).
REQ-007 SHALL define memWait = MemReqM and not MemReadyM, or state == TIMEOUT.
REQ-008 SHALL, when memWait is high, drive StallF = StallD = StallE = StallM = 1, FlushW = 1 and FlushD = FlushE = 0. This freeze overrides all other rules and defers PCSrcE handling until the freeze ends.
REQ-009 SHALL, when memWait is low and PCSrcE is high, drive FlushD = FlushE = 1 with all stalls 0. A taken branch suppresses lwStall because the instruction in Decode is wrong-path.
REQ-010 SHALL, when memWait and PCSrcE are low and lwStall is high, drive StallF = StallD = 1 and FlushE = 1, with all other stall and flush outputs 0.
REQ-011 SHALL otherwise drive all stall and flush outputs to 0.
REQ-012 SHALL make all of REQ-004 to REQ-011 combinational, with zero-cycle latency from the inputs.
REQ-013 SHALL implement a three-state FSM (pctl_state_e):
- RUN: on MemReqM and not MemReadyM, go to MWAIT with wcnt = 1.
- MWAIT: on MemReadyM, go to RUN with wcnt = 0. On MemReqM deasserting without MemReadyM, go to RUN with wcnt = 0. Otherwise wcnt increments; when wcnt == WAIT_MAX, go to TIMEOUT.
- TIMEOUT: absorbing until reset; MemErr = 1.
REQ-014 SHALL size wcnt as $clog2(WAIT_MAX+1) bits so that it never wraps before reaching WAIT_MAX.
REQ-015 SHALL let a MemReadyM that arrives in the same cycle wcnt reaches WAIT_MAX win, going to RUN with no error.
REQ-016 SHALL increment StallCnt on each clock edge where any Stall* output is 1, saturating at all-ones with no wrap.

Reset
REQ-017 SHALL, while rst_n is low, hold state = RUN, wcnt = 0, MemErr = 0 and StallCnt = 0.
REQ-018 SHALL, while rst_n is low, force ForwardAE = ForwardBE = FWD_NONE and all stall and flush outputs to 0, regardless of the other inputs.
REQ-019 SHALL, when reset asserts mid-wait or in TIMEOUT, clear the FSM state immediately and asynchronously.

Structure
REQ-020 SHALL place fwd_e (FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10) and pctl_state_e (RUN, MWAIT, TIMEOUT) in riscv_pkg.
REQ-021 SHALL implement the forwarding rule as one sub-module, fwd_unit, instantiated twice, for operands A and B.

Verification
REQ-022 SHALL cover forwarding from Memory:
- Stimulus: RegWriteM = 1, RdM = 5, Rs1E = 5, and RegWriteW = 1, RdW = 5.
- Required: ForwardAE = 2'b10; when RdM = 0 instead, ForwardAE = 2'b01.
REQ-023 SHALL cover load-use:
- Stimulus: LoadE = 1, RdE = 7, Rs2D = 7, PCSrcE = 0.
- Required: StallF = StallD = FlushE = 1 for exactly that cycle.
REQ-024 SHALL cover a simultaneous load-use and taken branch:
- Stimulus: inputs of REQ-023 plus PCSrcE = 1.
- Required: FlushD = FlushE = 1, StallF = StallD = 0.
REQ-025 SHALL cover a memory wait:
- Stimulus: MemReqM = 1 with MemReadyM low for 3 cycles, then high.
- Required: the four stalls and FlushW are high for 3 cycles, the FSM returns to RUN, and StallCnt = 3.
REQ-026 SHALL cover timeout:
- Stimulus: MemReqM = 1 and MemReadyM = 0 held with WAIT_MAX = 4.
- Required: MemErr rises after the 4th wait cycle and the stalls stay high; asserting rst_n = 0 clears MemErr and StallCnt asynchronously.
